wb_arbiter: RTL and testbench

- Shares the single execute/writeback port between the scalar, matrix and GEMM functional units.
- Round-robin arbitration among valid FU results, with a valid/ready handshake on both sides.
- The winner is registered into the execute/writeback latch (`ew_t` plus destination register and source-FU tag) feeding the register file.
- One grant per cycle; full throughput when downstream is ready.

---
 rtl/wb_arbiter_pkg.sv | 24 ++
 rtl/wb_arbiter_rr_arbiter.sv | 25 ++
 rtl/wb_arbiter.sv | 92 +++++++++
 tb/tb_wb_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types for the execute/writeback arbiter: result word, writeback latch and FU identifiers.
package wb_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t wb_data;
    } ew_t;

    localparam int unsigned NUM_FU = 3;

    typedef enum logic [1:0] {
        FU_SCALAR = 2'd0,
        FU_MATRIX = 2'd1,
        FU_GEMM   = 2'd2
    } fu_id_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        word_t      data;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, modulo N.
module rr_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter  int unsigned N  = 3,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!(|gnt) && req[(32'(ptr) + k) % N]) begin
                gnt[(32'(ptr) + k) % N] = 1'b1;
                gnt_idx                 = IW'((32'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing the execute/writeback latch between the functional units.
// Optional grant/conflict performance counters are enabled by defining WB_PERF_CNT_EN.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_FU = wb_arbiter_pkg::NUM_FU,
    parameter  int unsigned REG_W  = 5,
    parameter  int unsigned CNT_W  = 32,
    localparam int unsigned FU_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic [NUM_FU-1:0]             fu_valid,
    input  logic [NUM_FU-1:0][REG_W-1:0]  fu_rd,
    input  word_t [NUM_FU-1:0]            fu_data,
    output logic [NUM_FU-1:0]             fu_ready,
    input  logic                          wb_ready,
    output logic                          wb_valid,
    output ew_t                           wb_out,
    output logic [REG_W-1:0]              wb_rd,
    output logic [FU_W-1:0]               wb_fu
`ifdef WB_PERF_CNT_EN
    ,
    output logic [NUM_FU-1:0][CNT_W-1:0]  perf_grant,
    output logic [CNT_W-1:0]              perf_conflict
`endif
);

    logic              out_free;
    logic              transfer;
    logic [NUM_FU-1:0] req;
    logic [NUM_FU-1:0] gnt;
    logic [FU_W-1:0]   gnt_idx;
    logic [FU_W-1:0]   rr_ptr;

    // Requests are masked during reset so no FU sees an accept it cannot complete.
    assign out_free = !wb_valid || wb_ready;
    assign req      = (nRST && out_free) ? fu_valid : '0;
    assign transfer = |gnt;
    assign fu_ready = gnt;

    rr_arbiter #(.N(NUM_FU)) u_rr (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wb_valid <= 1'b0;
            wb_out   <= '0;
            wb_rd    <= '0;
            wb_fu    <= '0;
            rr_ptr   <= '0;
        end else if (transfer) begin
            // Writes to x0 are consumed but never presented downstream.
            wb_valid       <= |fu_rd[gnt_idx];
            wb_out.wb_data <= fu_data[gnt_idx];
            wb_rd          <= fu_rd[gnt_idx];
            wb_fu          <= gnt_idx;
            rr_ptr         <= (gnt_idx == FU_W'(NUM_FU - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (wb_ready) begin
            wb_valid <= 1'b0;
        end
    end

    if (CNT_W == 0) begin : g_cnt_w_zero
    end

`ifdef WB_PERF_CNT_EN
    logic multi_req;
    assign multi_req = out_free && ($countones(fu_valid) > 1);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_grant    <= '0;
            perf_conflict <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (gnt[i] && (perf_grant[i] != '1)) begin
                    perf_grant[i] <= perf_grant[i] + 1'b1;
                end
            end
            if (multi_req && (perf_conflict != '1)) begin
                perf_conflict <= perf_conflict + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios then randomized traffic against a reference model.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int NF = 3;

    logic              CLK = 1'b0;
    logic              nRST;
    logic [NF-1:0]     fu_valid;
    logic [NF-1:0][4:0] fu_rd;
    word_t [NF-1:0]    fu_data;
    logic [NF-1:0]     fu_ready;
    logic              wb_ready;
    logic              wb_valid;
    ew_t               wb_out;
    logic [4:0]        wb_rd;
    logic [1:0]        wb_fu;
`ifdef WB_PERF_CNT_EN
    logic [NF-1:0][31:0] perf_grant;
    logic [31:0]         perf_conflict;
`endif

    always #5 CLK = ~CLK;

    wb_arbiter #(.NUM_FU(3), .REG_W(5), .CNT_W(32)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .fu_valid (fu_valid),
        .fu_rd    (fu_rd),
        .fu_data  (fu_data),
        .fu_ready (fu_ready),
        .wb_ready (wb_ready),
        .wb_valid (wb_valid),
        .wb_out   (wb_out),
        .wb_rd    (wb_rd),
        .wb_fu    (wb_fu)
`ifdef WB_PERF_CNT_EN
        ,
        .perf_grant    (perf_grant),
        .perf_conflict (perf_conflict)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: output latch contents, rotation pointer, counters.
    bit          m_valid;
    logic [31:0] m_data;
    logic [4:0]  m_rd;
    int          m_fu;
    int          m_ptr;
    int          m_pg[NF];
    int          m_pc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_rd    = '0;
        m_fu    = 0;
        m_ptr   = 0;
        m_pc    = 0;
        for (int i = 0; i < NF; i++) m_pg[i] = 0;
    endfunction

    // Which FU should be accepted now, or -1: scan FUs starting at the pointer, wrapping.
    function automatic int pick();
        int order[$];
        if (!nRST || (m_valid && !wb_ready)) return -1;
        for (int k = 0; k < NF; k++) order.push_back((m_ptr + k) % NF);
        foreach (order[j]) if (fu_valid[order[j]]) return order[j];
        return -1;
    endfunction

    // Inputs are already driven; check accept, advance the model, clock, check the latch.
    task automatic cycle(output int g);
        #1;
        g = pick();
        check("fu_ready", 64'(fu_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        if (nRST && (!m_valid || wb_ready) && $countones(fu_valid) >= 2) m_pc++;
        if (g >= 0) begin
            m_valid = (fu_rd[g] != 0);
            m_data  = fu_data[g];
            m_rd    = fu_rd[g];
            m_fu    = g;
            m_ptr   = (g + 1) % NF;
            m_pg[g]++;
        end else if (wb_ready) begin
            m_valid = 1'b0;
        end
        @(posedge CLK);
        #1;
        check("wb_valid", 64'(wb_valid), 64'(m_valid));
        if (m_valid) begin
            check("wb_data", 64'(wb_out.wb_data), 64'(m_data));
            check("wb_rd",   64'(wb_rd),          64'(m_rd));
            check("wb_fu",   64'(wb_fu),          64'(m_fu));
        end
    endtask

    task automatic check_perf();
`ifdef WB_PERF_CNT_EN
        check("perf_conflict", 64'(perf_conflict), 64'(m_pc));
        for (int i = 0; i < NF; i++) check("perf_grant", 64'(perf_grant[i]), 64'(m_pg[i]));
`endif
    endtask

    function automatic void new_req(input int i, input bit allow_x0);
        fu_valid[i] = 1'b1;
        fu_rd[i]    = (allow_x0 && $urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        fu_data[i]  = $urandom;
    endfunction

    initial begin
        int g;
        nRST     = 1'b0;
        fu_valid = '0;
        fu_rd    = '0;
        fu_data  = '0;
        wb_ready = 1'b0;
        model_reset();
        #12;
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_wb_out",   64'(wb_out),   64'd0);
        check("rst_wb_rd",    64'(wb_rd),    64'd0);
        check("rst_wb_fu",    64'(wb_fu),    64'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        // Single requester: FU1 only
        fu_valid   = 3'b010;
        fu_rd[1]   = 5'd7;
        fu_data[1] = 32'hDEADBEEF;
        wb_ready   = 1'b1;
        cycle(g);
        fu_valid[1] = 1'b0;

        // Wrap: pointer sits at 2, FU0 and FU2 both waiting
        fu_valid   = 3'b101;
        fu_rd[0]   = 5'd3;  fu_data[0] = 32'h0000_1111;
        fu_rd[2]   = 5'd9;  fu_data[2] = 32'h2222_0000;
        cycle(g); fu_valid[g < 0 ? 0 : g] = 1'b0;
        cycle(g); fu_valid[g < 0 ? 0 : g] = 1'b0;

        // x0 drop still rotates the pointer
        fu_valid   = 3'b001;
        fu_rd[0]   = 5'd0;  fu_data[0] = 32'h1234_5678;
        cycle(g); fu_valid[0] = 1'b0;
        fu_valid   = 3'b011;
        fu_rd[0]   = 5'd4;  fu_rd[1] = 5'd5;
        cycle(g); fu_valid[g < 0 ? 0 : g] = 1'b0;
        cycle(g); fu_valid[g < 0 ? 0 : g] = 1'b0;

        // Back-pressure: FU0 latched, FU2 waits behind it
        fu_valid   = 3'b001;
        fu_rd[0]   = 5'd4;  fu_data[0] = 32'hA5A5_A5A5;
        cycle(g); fu_valid[0] = 1'b0;
        fu_valid   = 3'b100;
        fu_rd[2]   = 5'd12; fu_data[2] = 32'hC0FF_EE00;
        wb_ready   = 1'b0;
        for (int i = 0; i < 4; i++) cycle(g);
        wb_ready   = 1'b1;
        cycle(g); fu_valid[2] = 1'b0;

        // Asynchronous reset while a result is latched
        fu_valid = 3'b111;
        fu_rd[0] = 5'd1; fu_rd[1] = 5'd2; fu_rd[2] = 5'd3;
        wb_ready = 1'b0;
        #2;
        nRST = 1'b0;
        #1;
        model_reset();
        check("arst_wb_valid", 64'(wb_valid), 64'd0);
        check("arst_fu_ready", 64'(fu_ready), 64'd0);
        check("arst_wb_rd",    64'(wb_rd),    64'd0);
        @(posedge CLK);
        #1;
        nRST     = 1'b1;
        wb_ready = 1'b1;

        // Round-robin with all three continuously valid
        for (int n = 0; n < 6; n++) begin
            cycle(g);
            if (g >= 0) new_req(g, 1'b0);
        end
        check_perf();

        // Randomized traffic with random back-pressure and x0 writes
        for (int n = 0; n < 400; n++) begin
            wb_ready = ($urandom_range(0, 3) != 0);
            cycle(g);
            if (g >= 0) begin
                fu_valid[g] = 1'b0;
                if ($urandom_range(0, 1) == 1) new_req(g, 1'b1);
            end
            for (int i = 0; i < NF; i++) begin
                if (!fu_valid[i] && i != g && $urandom_range(0, 1) == 1) new_req(i, 1'b1);
            end
        end
        check_perf();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
